// File: rtl/datapath_sequencer.sv
// Moore control unit for the 4-bit datapath: sequences fetch/decode/execute/write/PC-increment
// over enable/ack handshakes, with a per-handshake watchdog, sticky error and retired-instruction count.
module datapath_sequencer #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             step,
  input  logic [1:0]       mnm_in,
  input  logic             ri_ack,
  input  logic             ula_ack,
  input  logic             wr_ack,
  input  logic             pc_ack,
  output logic             ena_ri,
  output logic             ena_ula,
  output logic             ena_wr,
  output logic             ena_pc,
  output logic             sel_r0_rd,
  output logic             sel_addr_data,
  output logic             sel_ldr_ula,
  output logic [2:0]       state_out,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXEC    = 3'd3,
    S_WRITE   = 3'd4,
    S_INCPC   = 3'd5,
    S_ILLEGAL = 3'd6,
    S_ERROR   = 3'd7
  } state_t;

  localparam logic [3:0] TMO_LAST = 4'(TIMEOUT - 1);

  state_t           state_q, state_d;
  state_t           adv_state;
  logic [3:0]       tmo_q, tmo_d;
  logic             ldr_q, ldr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             waiting;
  logic             ack;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      tmo_q   <= 4'd0;
      ldr_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      ldr_q   <= ldr_d;
      cnt_q   <= cnt_d;
    end
  end

  // adv_state is where a handshake state goes once its ack is seen.
  always_comb begin
    state_d   = state_q;
    adv_state = state_q;
    ldr_d     = ldr_q;
    cnt_d     = cnt_q;
    waiting   = 1'b0;
    ack       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run || step) state_d = S_FETCH;
      end
      S_FETCH: begin
        waiting   = 1'b1;
        ack       = ri_ack;
        adv_state = S_DECODE;
      end
      S_DECODE: begin
        ldr_d   = (mnm_in == 2'b00);
        state_d = (mnm_in == 2'b00) ? S_WRITE : S_EXEC;
      end
      S_EXEC: begin
        waiting   = 1'b1;
        ack       = ula_ack;
        adv_state = S_WRITE;
      end
      S_WRITE: begin
        waiting   = 1'b1;
        ack       = wr_ack;
        adv_state = S_INCPC;
      end
      S_INCPC: begin
        waiting   = 1'b1;
        ack       = pc_ack;
        adv_state = run ? S_FETCH : S_IDLE;
        if (pc_ack) cnt_d = cnt_q + CNT_W'(1);
      end
      S_ERROR: begin
        state_d = S_ERROR;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // An ack in the final allowed cycle still wins over the watchdog.
    if (waiting) begin
      if (ack) begin
        state_d = adv_state;
      end else if (tmo_q == TMO_LAST) begin
        state_d = S_ERROR;
      end
    end

    if (state_d != state_q) begin
      tmo_d = 4'd0;
    end else if (waiting) begin
      tmo_d = tmo_q + 4'd1;
    end else begin
      tmo_d = tmo_q;
    end
  end

  always_comb begin
    ena_ri        = 1'b0;
    ena_ula       = 1'b0;
    ena_wr        = 1'b0;
    ena_pc        = 1'b0;
    sel_r0_rd     = 1'b0;
    sel_addr_data = 1'b0;
    sel_ldr_ula   = 1'b0;
    busy          = 1'b0;
    err           = 1'b0;
    state_out     = state_q;
    case (state_q)
      S_FETCH: begin
        ena_ri = 1'b1;
        busy   = 1'b1;
      end
      S_DECODE: begin
        busy = 1'b1;
      end
      S_EXEC: begin
        ena_ula       = 1'b1;
        sel_addr_data = 1'b1;
        busy          = 1'b1;
      end
      S_WRITE: begin
        ena_wr        = 1'b1;
        sel_r0_rd     = ~ldr_q;
        sel_addr_data = ~ldr_q;
        sel_ldr_ula   = ldr_q;
        busy          = 1'b1;
      end
      S_INCPC: begin
        ena_pc = 1'b1;
        busy   = 1'b1;
      end
      S_ERROR: begin
        err = 1'b1;
      end
      S_ILLEGAL: begin
        state_out = 3'd0;
      end
      default: begin
      end
    endcase
  end

  assign instr_count = cnt_q;

endmodule
